// File: rtl/sign_add_sub_pkg.sv
// Shared definitions for the signed add/sub arbiter: FSM encoding and
// the signed-overflow rule applied to the primary result.
package sign_add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

   // Add overflows when like signs give a differently-signed result;
   // subtract overflows when unlike signs give a result unlike A.
   function automatic logic add_sub_ovf(input logic add, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
      logic sign_cond;
      sign_cond = add ? (a_msb == b_msb) : (a_msb != b_msb);
      return sign_cond && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/SignAddSub.sv
// Registered signed adder/subtractor, one-cycle latency.
// ResultA is the selected operation, ResultB the opposite one.
module SignAddSub #(
   parameter int INPUT_BIT_WIDTH = 8
) (
   input  logic                              Clk,
   input  logic signed [INPUT_BIT_WIDTH-1:0] A,
   input  logic signed [INPUT_BIT_WIDTH-1:0] B,
   input  logic                              AddSubMode,
   output logic signed [INPUT_BIT_WIDTH-1:0] ResultA,
   output logic signed [INPUT_BIT_WIDTH-1:0] ResultB
);

   always_ff @(posedge Clk) begin
      ResultA <= AddSubMode ? (A + B) : (A - B);
      ResultB <= AddSubMode ? (A - B) : (A + B);
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
// Emits a one-hot grant and its encoded index (zero when nothing requests).
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx
);

   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         cand = IDW'((int'(last) + k) % N);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/sign_add_sub_arbiter.sv
// Round-robin sequencer sharing one registered SignAddSub among N clients;
// returns primary/alternate results tagged with client id and overflow.
module sign_add_sub_arbiter
   import sign_add_sub_pkg::*;
#(
   parameter int INPUT_BIT_WIDTH = 8,
   parameter int REQUESTERS      = 4,
   parameter int ID_WIDTH        = 2
) (
   input  logic                                  Clk,
   input  logic                                  Reset,
   input  logic [REQUESTERS-1:0]                 ReqValid,
   input  logic [REQUESTERS*INPUT_BIT_WIDTH-1:0] ReqA,
   input  logic [REQUESTERS*INPUT_BIT_WIDTH-1:0] ReqB,
   input  logic [REQUESTERS-1:0]                 ReqMode,
   output logic [REQUESTERS-1:0]                 ReqReady,
   output logic                                  RespValid,
   input  logic                                  RespReady,
   output logic [ID_WIDTH-1:0]                   RespId,
   output logic signed [INPUT_BIT_WIDTH-1:0]     RespResult,
   output logic signed [INPUT_BIT_WIDTH-1:0]     RespAlt,
   output logic                                  RespOverflow,
   output logic                                  Busy
);

   localparam int W = INPUT_BIT_WIDTH;

   state_t                state, state_nxt;
   logic [ID_WIDTH-1:0]   last_grant, pick_idx;
   logic [REQUESTERS-1:0] pick_gnt;
   logic                  accept;

   logic signed [W-1:0]   a_p0, b_p0;
   logic                  mode_p0;
   logic [ID_WIDTH-1:0]   id_p0;
   logic signed [W-1:0]   res_p1, alt_p1;

   rr_pick #(.N(REQUESTERS), .IDW(ID_WIDTH)) u_pick (
      .req (ReqValid),
      .last(last_grant),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   always_comb begin
      state_nxt = state;
      ReqReady  = '0;
      case (state)
         IDLE: if (|ReqValid) begin
            ReqReady  = pick_gnt;
            state_nxt = EXEC;
         end
         EXEC: state_nxt = CAPT;
         CAPT: state_nxt = RESP;
         RESP: if (RespReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = (state == IDLE) && (|ReqValid);
   assign Busy   = (state != IDLE);

   // stage p0: latched operands drive the shared unit during EXEC
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         last_grant   <= ID_WIDTH'(REQUESTERS - 1);
         a_p0         <= '0;
         b_p0         <= '0;
         mode_p0      <= 1'b0;
         id_p0        <= '0;
         RespValid    <= 1'b0;
         RespId       <= '0;
         RespResult   <= '0;
         RespAlt      <= '0;
         RespOverflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            last_grant <= pick_idx;
            a_p0       <= ReqA[pick_idx*W +: W];
            b_p0       <= ReqB[pick_idx*W +: W];
            mode_p0    <= ReqMode[pick_idx];
            id_p0      <= pick_idx;
         end
         // stage p1: unit outputs valid in CAPT, captured into the response
         if (state == CAPT) begin
            RespValid    <= 1'b1;
            RespId       <= id_p0;
            RespResult   <= res_p1;
            RespAlt      <= alt_p1;
            RespOverflow <= add_sub_ovf(mode_p0, a_p0[W-1], b_p0[W-1], res_p1[W-1]);
         end else if (state == RESP && RespReady) begin
            RespValid <= 1'b0;
         end
      end
   end

   SignAddSub #(.INPUT_BIT_WIDTH(INPUT_BIT_WIDTH)) u_addsub (
      .Clk       (Clk),
      .A         (a_p0),
      .B         (b_p0),
      .AddSubMode(mode_p0),
      .ResultA   (res_p1),
      .ResultB   (alt_p1)
   );

endmodule
